// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates the condition, target, link and mispredict
// for one branch per cycle into a one-entry output register with a valid/ready drain.
// Optional BRANCH_UNIT_STATS_EN adds resolved/mispredict handshake counters.
module branch_unit #(
  parameter int XLEN   = 32,
  parameter int ROB_IX = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [XLEN-1:0]   rval1_in,
  input  logic [XLEN-1:0]   rval2_in,
  input  logic [2:0]        brFunc_in,
  input  logic              jalr_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   imm_in,
  input  logic              pred_taken_in,
  input  logic [XLEN-1:0]   pred_target_in,
  input  logic [ROB_IX-1:0] rob_ix_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              taken_out,
  output logic [XLEN-1:0]   target_out,
  output logic [XLEN-1:0]   link_out,
  output logic [XLEN-1:0]   redirect_out,
  output logic              mispredict_out,
  output logic [ROB_IX-1:0] rob_ix_out
`ifdef BRANCH_UNIT_STATS_EN
  ,
  output logic [31:0]       stat_resolved_out,
  output logic [31:0]       stat_mispredict_out
`endif
);

  localparam logic [2:0] F_EQ  = 3'd0;
  localparam logic [2:0] F_NEQ = 3'd1;
  localparam logic [2:0] F_LT  = 3'd2;
  localparam logic [2:0] F_LTU = 3'd3;
  localparam logic [2:0] F_GE  = 3'd4;
  localparam logic [2:0] F_GEU = 3'd5;
  localparam logic [2:0] F_DBR = 3'd6;

  typedef struct packed {
    logic              taken;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   link;
    logic [XLEN-1:0]   redirect;
    logic              mispredict;
    logic [ROB_IX-1:0] rob_ix;
  } res_t;

  res_t            res_d, res_q;
  logic            valid_q;
  logic            accept;
  logic [XLEN-1:0] sum_pc, sum_rs;

  assign ready_out = !valid_q || ready_in;
  assign accept    = valid_in && ready_out && !flush_in;

  always_comb begin
    res_d  = '0;
    sum_pc = pc_in + imm_in;
    sum_rs = rval1_in + imm_in;
    unique case (brFunc_in)
      F_EQ:    res_d.taken = (rval1_in == rval2_in);
      F_NEQ:   res_d.taken = (rval1_in != rval2_in);
      F_LT:    res_d.taken = ($signed(rval1_in) <  $signed(rval2_in));
      F_LTU:   res_d.taken = (rval1_in <  rval2_in);
      F_GE:    res_d.taken = ($signed(rval1_in) >= $signed(rval2_in));
      F_GEU:   res_d.taken = (rval1_in >= rval2_in);
      F_DBR:   res_d.taken = 1'b1;
      default: res_d.taken = 1'b0;
    endcase
    // JALR clears bit 0 of the register-relative target
    res_d.target     = (jalr_in && brFunc_in == F_DBR) ? {sum_rs[XLEN-1:1], 1'b0} : sum_pc;
    res_d.link       = pc_in + XLEN'(4);
    res_d.redirect   = res_d.taken ? res_d.target : res_d.link;
    res_d.mispredict = (res_d.taken != pred_taken_in) ||
                       (res_d.taken && res_d.target != pred_target_in);
    res_d.rob_ix     = rob_ix_in;
  end

  // flush beats accept beats drain
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      if (flush_in)     valid_q <= 1'b0;
      else if (accept)  valid_q <= 1'b1;
      else if (ready_in) valid_q <= 1'b0;
      if (accept) res_q <= res_d;
    end
  end

  assign valid_out      = valid_q;
  assign taken_out      = res_q.taken;
  assign target_out     = res_q.target;
  assign link_out       = res_q.link;
  assign redirect_out   = res_q.redirect;
  assign mispredict_out = res_q.mispredict;
  assign rob_ix_out     = res_q.rob_ix;

`ifdef BRANCH_UNIT_STATS_EN
  logic handshake;
  assign handshake = valid_q && ready_in && !flush_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_resolved_out   <= '0;
      stat_mispredict_out <= '0;
    end else if (handshake) begin
      stat_resolved_out <= stat_resolved_out + 32'd1;
      if (res_q.mispredict) stat_mispredict_out <= stat_mispredict_out + 32'd1;
    end
  end
`endif

endmodule
